// File: rtl/clipper_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | clipper_pkg: shared types and widths for the Clipper timebase           |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
package clipper_pkg;

    localparam int TB_WIDTH       = 64;
    localparam int TB_PHASE_WIDTH = 32;

    typedef enum logic [1:0] {
        TB_IDLE   = 2'd0,
        TB_RUN    = 2'd1,
        TB_FROZEN = 2'd2,
        TB_LOAD   = 2'd3
    } tb_state_e;

endpackage
`default_nettype wire

// File: rtl/clipper_timebase_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | clipper_timebase_ctrl_if: control/status bundle of the timebase         |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
interface clipper_timebase_ctrl_if;
    import clipper_pkg::*;

    logic                ena;
    logic                freeze;
    logic                accelerate;
    logic                force_req;
    logic [TB_WIDTH-1:0] force_time;
    logic                force_ack;
    logic [TB_WIDTH-1:0] time_o;
    logic                time_valid;
    logic                tick;
    logic [1:0]          state_o;

    modport master (
        output ena, freeze, accelerate, force_req, force_time,
        input  force_ack, time_o, time_valid, tick, state_o
    );

    modport slave (
        input  ena, freeze, accelerate, force_req, force_time,
        output force_ack, time_o, time_valid, tick, state_o
    );

endinterface
`default_nettype wire

// File: rtl/clipper_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | clipper_tick_gen: phase accumulator producing one strobe per period     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module clipper_tick_gen
    import clipper_pkg::*;
#(
    parameter int unsigned TICK_PERIOD_NS = 1000000
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic [TB_PHASE_WIDTH-1:0] inc_i,
    input  wire logic                      advance_i,
    input  wire logic                      clear_i,
    output logic                           tick_o
);

    localparam logic [TB_PHASE_WIDTH:0] PERIOD = (TB_PHASE_WIDTH+1)'(TICK_PERIOD_NS);

    logic [TB_PHASE_WIDTH-1:0] phase_q, phase_d;
    logic                      tick_q, tick_d;
    logic [TB_PHASE_WIDTH:0]   sum_w;
    logic [TB_PHASE_WIDTH:0]   wrapped_w;

    // One extra bit keeps phase+inc from overflowing before the compare.
    assign sum_w     = {1'b0, phase_q} + {1'b0, inc_i};
    assign wrapped_w = sum_w - PERIOD;

    always_comb begin
        phase_d = phase_q;
        tick_d  = 1'b0;
        if (clear_i) begin
            phase_d = '0;
        end else if (advance_i) begin
            if (sum_w >= PERIOD) begin
                phase_d = wrapped_w[TB_PHASE_WIDTH-1:0];
                tick_d  = 1'b1;
            end else begin
                phase_d = sum_w[TB_PHASE_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/clipper_timebase_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | clipper_timebase_ctrl: 64-bit ns timebase sequencer with force-load     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module clipper_timebase_ctrl
    import clipper_pkg::*;
#(
    parameter int unsigned INC_NS         = 8,
    parameter int unsigned ACCEL_SHIFT    = 4,
    parameter int unsigned TICK_PERIOD_NS = 1000000
) (
    input  wire logic                clk,
    input  wire logic                rst,
    clipper_timebase_ctrl_if.slave   ctrl_if
);

    localparam logic [TB_WIDTH-1:0] INC_NORM  = TB_WIDTH'(INC_NS);
    localparam logic [TB_WIDTH-1:0] INC_ACCEL = INC_NORM << ACCEL_SHIFT;

    tb_state_e           state_q, state_d;
    logic [TB_WIDTH-1:0] time_q, time_d;
    logic                valid_q, valid_d;
    logic                ack_q, ack_d;
    logic                armed_q, armed_d;

    logic [TB_WIDTH-1:0] inc_w;
    logic                force_w;
    logic                advance_w;
    logic                load_w;
    logic                tick_w;

    assign inc_w   = ctrl_if.accelerate ? INC_ACCEL : INC_NORM;
    // A request only counts once it has been seen low since the last load.
    assign force_w = ctrl_if.force_req & armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TB_IDLE: begin
                if (force_w)                                  state_d = TB_LOAD;
                else if (ctrl_if.ena && !ctrl_if.freeze)      state_d = TB_RUN;
                else if (ctrl_if.ena)                         state_d = TB_FROZEN;
            end
            TB_RUN: begin
                if (!ctrl_if.ena)                             state_d = TB_IDLE;
                else if (force_w)                             state_d = TB_LOAD;
                else if (ctrl_if.freeze)                      state_d = TB_FROZEN;
            end
            TB_FROZEN: begin
                if (!ctrl_if.ena)                             state_d = TB_IDLE;
                else if (force_w)                             state_d = TB_LOAD;
                else if (!ctrl_if.freeze)                     state_d = TB_RUN;
            end
            TB_LOAD: begin
                if (!ctrl_if.ena)                             state_d = TB_IDLE;
                else if (ctrl_if.freeze)                      state_d = TB_FROZEN;
                else                                          state_d = TB_RUN;
            end
            default:                                          state_d = TB_IDLE;
        endcase
    end

    always_comb begin
        time_d    = time_q;
        valid_d   = valid_q;
        ack_d     = 1'b0;
        armed_d   = armed_q | ~ctrl_if.force_req;
        advance_w = 1'b0;
        load_w    = 1'b0;
        case (state_q)
            TB_RUN: begin
                time_d    = time_q + inc_w;
                valid_d   = 1'b1;
                advance_w = 1'b1;
            end
            TB_LOAD: begin
                time_d  = ctrl_if.force_time;
                valid_d = 1'b1;
                ack_d   = 1'b1;
                armed_d = 1'b0;
                load_w  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            time_q  <= time_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            armed_q <= armed_d;
        end
    end

    clipper_tick_gen #(
        .TICK_PERIOD_NS (TICK_PERIOD_NS)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (inc_w[TB_PHASE_WIDTH-1:0]),
        .advance_i (advance_w),
        .clear_i   (load_w),
        .tick_o    (tick_w)
    );

    assign ctrl_if.time_o     = time_q;
    assign ctrl_if.time_valid = valid_q;
    assign ctrl_if.force_ack  = ack_q;
    assign ctrl_if.tick       = tick_w;
    assign ctrl_if.state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_clipper_timebase_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_clipper_timebase_ctrl: scoreboard bench for the timebase sequencer   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_clipper_timebase_ctrl;
    import clipper_pkg::*;

    localparam int unsigned INC = 8;
    localparam int unsigned SH  = 4;
    localparam int unsigned PER = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clipper_timebase_ctrl_if bus ();

    clipper_timebase_ctrl #(
        .INC_NS         (INC),
        .ACCEL_SHIFT    (SH),
        .TICK_PERIOD_NS (PER)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus.slave)
    );

    typedef struct {
        logic [63:0] t;
        logic        v;
        logic        a;
        logic        k;
        logic [1:0]  s;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   passed  = 0;
    int   tick_cnt = 0;
    int   ack_cnt  = 0;

    // Reference state: time plus total ns elapsed since the last phase clear.
    tb_state_e   m_st = TB_IDLE;
    logic [63:0] m_time = '0;
    logic [63:0] m_el = '0;
    logic        m_valid = 1'b0, m_ack = 1'b0, m_tick = 1'b0, m_armed = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        logic [63:0] inc;
        tb_state_e   ns;
        exp_t        e;
        if (rst) begin
            m_st = TB_IDLE; m_time = '0; m_el = '0;
            m_valid = 1'b0; m_ack = 1'b0; m_tick = 1'b0; m_armed = 1'b1;
        end else begin
            inc    = bus.accelerate ? (64'(INC) << SH) : 64'(INC);
            ns     = m_st;
            m_ack  = 1'b0;
            m_tick = 1'b0;
            case (m_st)
                TB_IDLE: begin
                    if (bus.force_req && m_armed)        ns = TB_LOAD;
                    else if (bus.ena && !bus.freeze)     ns = TB_RUN;
                    else if (bus.ena)                    ns = TB_FROZEN;
                end
                TB_RUN: begin
                    m_time  = m_time + inc;
                    m_valid = 1'b1;
                    m_tick  = ((m_el + inc) / PER) != (m_el / PER);
                    m_el    = m_el + inc;
                    if (!bus.ena)                        ns = TB_IDLE;
                    else if (bus.force_req && m_armed)   ns = TB_LOAD;
                    else if (bus.freeze)                 ns = TB_FROZEN;
                end
                TB_FROZEN: begin
                    if (!bus.ena)                        ns = TB_IDLE;
                    else if (bus.force_req && m_armed)   ns = TB_LOAD;
                    else if (!bus.freeze)                ns = TB_RUN;
                end
                default: begin
                    m_time  = bus.force_time;
                    m_el    = '0;
                    m_valid = 1'b1;
                    m_ack   = 1'b1;
                    ns = !bus.ena ? TB_IDLE : (bus.freeze ? TB_FROZEN : TB_RUN);
                end
            endcase
            if (m_st == TB_LOAD)  m_armed = 1'b0;
            else if (!bus.force_req) m_armed = 1'b1;
            m_st = ns;
        end
        e.t = m_time; e.v = m_valid; e.a = m_ack; e.k = m_tick; e.s = m_st;
        q.push_back(e);
    endtask

    // Inputs are set at a negedge; the model predicts the next edge's outputs.
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("time_o",     bus.time_o,     e.t);
            chk("time_valid", bus.time_valid, 64'(e.v));
            chk("force_ack",  bus.force_ack,  64'(e.a));
            chk("tick",       bus.tick,       64'(e.k));
            chk("state_o",    bus.state_o,    64'(e.s));
            if (bus.tick)      tick_cnt++;
            if (bus.force_ack) ack_cnt++;
        end
    end

    initial begin
        int   t0, a0;
        logic seen;
        bus.ena = 0; bus.freeze = 0; bus.accelerate = 0;
        bus.force_req = 0; bus.force_time = '0;
        @(negedge clk);
        step(); step();

        // Normal run then accelerate
        rst = 0; bus.ena = 1;
        repeat (11) step();
        chk("t1_time", bus.time_o, 64'd80);
        chk("t1_state", bus.state_o, 64'(TB_RUN));
        bus.accelerate = 1;
        repeat (5) step();
        chk("t2_accel_time", bus.time_o, 64'd720);
        bus.accelerate = 0;
        step();
        chk("t2_norm_time", bus.time_o, 64'd728);

        // Force load held long: exactly one ack
        a0 = ack_cnt;
        bus.force_time = 64'h1234_0000_0000_0000; bus.force_req = 1;
        repeat (22) step();
        bus.force_req = 0;
        step();
        chk("t3_single_ack", 64'(ack_cnt - a0), 64'd1);

        // Freeze, resume, force while frozen
        bus.freeze = 1;
        repeat (50) step();
        chk("t4_frozen", bus.state_o, 64'(TB_FROZEN));
        bus.freeze = 0;
        repeat (3) step();
        bus.freeze = 1;
        step(); step();
        bus.force_time = 64'h0000_00AB_CDEF_0000; bus.force_req = 1;
        repeat (4) step();
        bus.force_req = 0;
        step();
        chk("t4_back_frozen", bus.state_o, 64'(TB_FROZEN));
        bus.freeze = 0;

        // Wrap and normal tick spacing
        bus.force_time = 64'hFFFF_FFFF_FFFF_FFF8; bus.force_req = 1;
        step(); step();
        bus.force_req = 0;
        t0 = tick_cnt;
        step();
        chk("t5_wrap", bus.time_o, 64'd0);
        repeat (249) step();
        chk("t5_ticks_norm", 64'(tick_cnt - t0), 64'd2);

        // Accelerated tick spacing after a fresh load
        bus.force_time = '0; bus.force_req = 1;
        step(); step();
        bus.force_req = 0; bus.accelerate = 1;
        t0 = tick_cnt;
        repeat (63) step();
        chk("t5_ticks_accel", 64'(tick_cnt - t0), 64'd8);
        bus.accelerate = 0;

        // Async reset the cycle after a force request is first sampled
        a0 = ack_cnt;
        bus.force_time = 64'hDEAD_BEEF_0000_0001; bus.force_req = 1;
        step();
        rst = 1;
        #1;
        chk("t6_time",  bus.time_o,     64'd0);
        chk("t6_valid", bus.time_valid, 64'd0);
        chk("t6_ack",   bus.force_ack,  64'd0);
        chk("t6_state", bus.state_o,    64'(TB_IDLE));
        model_step();
        @(negedge clk);
        bus.force_req = 0;
        step();
        rst = 0;
        step(); step();
        chk("t6_no_ack", 64'(ack_cnt - a0), 64'd0);

        // Randomised traffic against the reference model
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus.ena = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) bus.freeze = ~bus.freeze;
            if ($urandom_range(0, 5) == 0) bus.accelerate = ~bus.accelerate;
            if (!bus.force_req) begin
                if ($urandom_range(0, 19) == 0) begin
                    bus.force_req  = 1;
                    bus.force_time = {$urandom, $urandom};
                    seen = 1'b0;
                end
            end else if (seen && $urandom_range(0, 2) == 0) begin
                bus.force_req = 0;
            end
            step();
            if (m_ack) seen = 1'b1;
        end

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
